// File: rtl/ahb2apb_bridge_v2_pkg.sv
// Shared types and constants for the AHB-Lite to APB4 bridge.
// Holds the FSM state encoding, the HTRANS codes and the AHB-to-APB protection mapping.
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam int IDX_BITS = 4;

  // hprot[0]=data, hprot[1]=privileged -> pprot = {instruction, secure(0), privileged}
  function automatic logic [2:0] ahb_to_pprot(input logic [1:0] hprot_lo);
    return {~hprot_lo[0], 1'b0, hprot_lo[1]};
  endfunction

endpackage

// File: rtl/ahb2apb_bridge_v2_apb_rsp_mux.sv
// Selects PREADY/PSLVERR/PRDATA of the addressed APB slave.
// Slave indices at or above PSLV_NUM select nothing and return zeros.
module apb_rsp_mux
  import ahb_apb_pkg::*;
#(
  parameter int PSLV_NUM   = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic [IDX_BITS-1:0]            idx,
  input  logic [PSLV_NUM-1:0]            pready_i,
  input  logic [PSLV_NUM-1:0]            pslverr_i,
  input  logic [PSLV_NUM*DATA_WIDTH-1:0] prdata_i,
  output logic                           sel_pready,
  output logic                           sel_pslverr,
  output logic [DATA_WIDTH-1:0]          sel_prdata
);

  // AND-OR select so an out-of-range index can never alias another slave
  always_comb begin
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    sel_prdata  = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < PSLV_NUM; k++) begin
      sel_pready  = sel_pready  | (pready_i[k]  & (idx == IDX_BITS'(k)));
      sel_pslverr = sel_pslverr | (pslverr_i[k] & (idx == IDX_BITS'(k)));
      sel_prdata  = sel_prdata  |
                    (prdata_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{idx == IDX_BITS'(k)}});
    end
  end

endmodule

// File: rtl/ahb2apb_bridge_v2.sv
// AHB-Lite slave to APB4 master bridge with base/slave decode, error responses
// and a PREADY timeout; the APB side advances only on pclken-qualified edges.
module ahb2apb_bridge_v2
  import ahb_apb_pkg::*;
#(
  parameter int                     HADDR_WIDTH = 32,
  parameter int                     PADDR_WIDTH = 16,
  parameter int                     DATA_WIDTH  = 32,
  parameter int                     PSLV_NUM    = 5,
  parameter logic [HADDR_WIDTH-1:0] BASE_ADDR   = 32'h4000_0000,
  parameter int                     TIMEOUT_CYC = 256
) (
  input  logic                           hclk,
  input  logic                           hreset,
  input  logic                           pclken,
  input  logic                           hsel,
  input  logic [HADDR_WIDTH-1:0]         haddr,
  input  logic [1:0]                     htrans,
  input  logic                           hwrite,
  input  logic [2:0]                     hsize,
  input  logic [3:0]                     hprot,
  input  logic [DATA_WIDTH-1:0]          hwdata,
  input  logic [DATA_WIDTH/8-1:0]        hwstrb,
  input  logic                           hready_i,
  output logic                           hready_o,
  output logic                           hresp_o,
  output logic [DATA_WIDTH-1:0]          hrdata_o,
  output logic [PADDR_WIDTH-1:0]         paddr,
  output logic [PSLV_NUM-1:0]            psel,
  output logic                           penable,
  output logic                           pwrite,
  output logic [DATA_WIDTH-1:0]          pwdata,
  output logic [DATA_WIDTH/8-1:0]        pstrb,
  output logic [2:0]                     pprot,
  input  logic [PSLV_NUM-1:0]            pready_i,
  input  logic [PSLV_NUM*DATA_WIDTH-1:0] prdata_i,
  input  logic [PSLV_NUM-1:0]            pslverr_i
);

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int TAG_LSB = PADDR_WIDTH + IDX_BITS;
  localparam int CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t                  state_r, state_nxt_s;
  logic [IDX_BITS-1:0]     idx_r, haddr_idx_s;
  logic [PADDR_WIDTH-1:0]  addr_r;
  logic                    hwrite_r;
  logic [1:0]              hprot_r;
  logic [CNT_W-1:0]        tcnt_r;
  logic                    xfer_req_s, accept_s, mapped_s;
  logic                    sel_pready_s, sel_pslverr_s, timeout_s;
  logic [DATA_WIDTH-1:0]   sel_prdata_s;
  logic                    capture_s, setup_ld_s, access_ld_s, done_s, abort_s;
  logic                    hready_nxt_s, hresp_nxt_s;
  logic [PSLV_NUM-1:0]     psel_onehot_s;
  logic                    unused_s;

  assign unused_s    = ^{hsize, hprot[3:2]};
  assign haddr_idx_s = haddr[PADDR_WIDTH +: IDX_BITS];
  assign mapped_s    = (haddr[HADDR_WIDTH-1:TAG_LSB] == BASE_ADDR[HADDR_WIDTH-1:TAG_LSB]) &&
                       ({1'b0, haddr_idx_s} < (IDX_BITS+1)'(PSLV_NUM));
  assign accept_s    = hsel & hready_i & xfer_req_s;
  assign timeout_s   = (TIMEOUT_CYC != 0) && pclken && !sel_pready_s && (tcnt_r == TO_LAST);

  apb_rsp_mux #(.PSLV_NUM(PSLV_NUM), .DATA_WIDTH(DATA_WIDTH)) u_rsp_mux (
    .idx         (idx_r),
    .pready_i    (pready_i),
    .pslverr_i   (pslverr_i),
    .prdata_i    (prdata_i),
    .sel_pready  (sel_pready_s),
    .sel_pslverr (sel_pslverr_s),
    .sel_prdata  (sel_prdata_s)
  );

  // Only NONSEQ/SEQ start a transfer; IDLE/BUSY are ignored
  always_comb begin
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: xfer_req_s = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  xfer_req_s = 1'b0;
      default:                   xfer_req_s = 1'b0;
    endcase
  end

  // Decode the latched slave index into the one-hot PSEL pattern
  always_comb begin
    psel_onehot_s = {PSLV_NUM{1'b0}};
    for (int k = 0; k < PSLV_NUM; k++) psel_onehot_s[k] = (idx_r == IDX_BITS'(k));
  end

  // FSM state register
  always_ff @(posedge hclk) begin
    if (hreset) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_ERR2: begin
        if (accept_s && mapped_s) state_nxt_s = ST_WAIT;
        else if (accept_s)        state_nxt_s = ST_ERR1;
        else                      state_nxt_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (pclken) state_nxt_s = ST_SETUP;
        else        state_nxt_s = ST_WAIT;
      end
      ST_SETUP: begin
        if (pclken) state_nxt_s = ST_ACCESS;
        else        state_nxt_s = ST_SETUP;
      end
      ST_ACCESS: begin
        if (pclken && sel_pready_s) state_nxt_s = sel_pslverr_s ? ST_ERR1 : ST_IDLE;
        else if (timeout_s)         state_nxt_s = ST_ERR1;
        else                        state_nxt_s = ST_ACCESS;
      end
      ST_ERR1: state_nxt_s = ST_ERR2;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: datapath load strobes and the next AHB handshake values
  always_comb begin
    capture_s   = 1'b0;
    setup_ld_s  = 1'b0;
    access_ld_s = 1'b0;
    done_s      = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_ERR2: capture_s   = accept_s;
      ST_WAIT:          setup_ld_s  = pclken;
      ST_SETUP:         access_ld_s = pclken;
      ST_ACCESS: begin
        done_s  = pclken & sel_pready_s;
        abort_s = timeout_s;
      end
      default:          capture_s   = 1'b0;
    endcase
    hready_nxt_s = (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_ERR2);
    hresp_nxt_s  = (state_nxt_s == ST_ERR1) || (state_nxt_s == ST_ERR2);
  end

  // ACCESS-phase pclken pulse counter, cleared on entry to ACCESS
  always_ff @(posedge hclk) begin
    if (hreset)                                  tcnt_r <= {CNT_W{1'b0}};
    else if (access_ld_s)                        tcnt_r <= {CNT_W{1'b0}};
    else if ((state_r == ST_ACCESS) && pclken)   tcnt_r <= tcnt_r + CNT_W'(1);
    else                                         tcnt_r <= tcnt_r;
  end

  // Address-phase capture, APB drive and AHB response registers
  always_ff @(posedge hclk) begin
    if (hreset) begin
      addr_r   <= {PADDR_WIDTH{1'b0}};
      idx_r    <= {IDX_BITS{1'b0}};
      hwrite_r <= 1'b0;
      hprot_r  <= 2'b00;
      psel     <= {PSLV_NUM{1'b0}};
      penable  <= 1'b0;
      paddr    <= {PADDR_WIDTH{1'b0}};
      pwrite   <= 1'b0;
      pwdata   <= {DATA_WIDTH{1'b0}};
      pstrb    <= {STRB_W{1'b0}};
      pprot    <= 3'b000;
      hrdata_o <= {DATA_WIDTH{1'b0}};
      hready_o <= 1'b1;
      hresp_o  <= 1'b0;
    end else begin
      hready_o <= hready_nxt_s;
      hresp_o  <= hresp_nxt_s;
      if (capture_s) begin
        addr_r   <= haddr[PADDR_WIDTH-1:0];
        idx_r    <= haddr_idx_s;
        hwrite_r <= hwrite;
        hprot_r  <= hprot[1:0];
      end
      // hwdata is held by the master while hready_o is low, so it is sampled live here
      if (setup_ld_s) begin
        psel    <= psel_onehot_s;
        penable <= 1'b0;
        paddr   <= addr_r;
        pwrite  <= hwrite_r;
        pwdata  <= hwdata;
        pstrb   <= hwrite_r ? hwstrb : {STRB_W{1'b0}};
        pprot   <= ahb_to_pprot(hprot_r);
      end
      if (access_ld_s) penable <= 1'b1;
      if (done_s || abort_s) begin
        psel    <= {PSLV_NUM{1'b0}};
        penable <= 1'b0;
      end
      if (done_s && !hwrite_r && !sel_pslverr_s) hrdata_o <= sel_prdata_s;
    end
  end

endmodule

// File: tb/tb_ahb2apb_bridge_v2.sv
// Self-checking bench for ahb2apb_bridge_v2: directed vector table, reset corner
// cases and randomized transfers against a transaction-level reference model.
module tb_ahb2apb_bridge_v2;

  localparam int NS = 5;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          hclk = 1'b0;
  logic          hreset, pclken, hsel, hwrite, hready_i;
  logic [31:0]   haddr, hwdata;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic [3:0]    hprot, hwstrb;
  logic          hready_o, hresp_o, penable, pwrite;
  logic [31:0]   hrdata_o, pwdata;
  logic [15:0]   paddr;
  logic [NS-1:0] psel, pready_i, pslverr_i;
  logic [3:0]    pstrb;
  logic [2:0]    pprot;
  logic [NS*DW-1:0] prdata_i;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] exp_hrdata;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [3:0]  prot;
    int          pck_n;   // 0 = random pclken, N = pclken every Nth edge
    int          wait_n;  // pclken edges in ACCESS with PREADY low
    logic        err;
    logic [31:0] rdata;
    logic [4:0]  exp_psel;
    logic        exp_resp;
    int          exp_low; // -1 = not checked
  } vec_t;

  ahb2apb_bridge_v2 #(.TIMEOUT_CYC(TO)) dut (
    .hclk(hclk), .hreset(hreset), .pclken(pclken), .hsel(hsel), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
    .hwstrb(hwstrb), .hready_i(hready_i), .hready_o(hready_o), .hresp_o(hresp_o),
    .hrdata_o(hrdata_o), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .pready_i(pready_i),
    .prdata_i(prdata_i), .pslverr_i(pslverr_i)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decode and response from the address map alone
  function automatic vec_t mk_exp(input vec_t v);
    vec_t r;
    bit   mapped;
    r      = v;
    mapped = (v.addr[31:20] == 12'h400) && (v.addr[19:16] < 4'd5);
    r.exp_psel = mapped ? (5'b00001 << v.addr[19:16]) : 5'b00000;
    r.exp_resp = !mapped || v.err || (v.wait_n >= TO);
    r.exp_low  = -1;
    return r;
  endfunction

  task automatic xfer(input vec_t v);
    int          ii, kk, pe, cyc, low;
    bit          mapped, err1_seen, done, pck;
    logic [63:0] bus, snap, exp_bus;
    ii     = int'(v.addr[19:16]);
    mapped = (v.exp_psel != 5'b00000);
    kk     = !mapped ? 0 : (2 + ((v.wait_n >= TO) ? TO : v.wait_n + 1));
    for (int s = 0; s < NS; s++) prdata_i[s*DW +: DW] = $urandom;
    pslverr_i = 5'($urandom);
    pready_i  = 5'($urandom);
    if (mapped) begin
      prdata_i[ii*DW +: DW] = v.rdata;
      pslverr_i[ii] = v.err;
      pready_i[ii]  = 1'b0;
    end
    hsel = 1'b1; haddr = v.addr; htrans = 2'b10; hwrite = v.wr; hprot = v.prot;
    hsize = 3'b010; hready_i = 1'b1; pclken = 1'($urandom);
    @(posedge hclk); #1;
    hsel = 1'($urandom); htrans = 2'($urandom_range(0, 1)); haddr = $urandom;
    hwrite = 1'($urandom); hwdata = v.wdata; hwstrb = v.strb;
    exp_bus = {2'b00, v.exp_psel, 1'b0, v.addr[15:0], v.wr, (v.wr ? v.strb : 4'b0000),
               ~v.prot[0], 1'b0, v.prot[1], v.wdata};
    pe = 0; cyc = 0; low = 0; err1_seen = 0; done = 0;
    while (!done) begin
      bus = {2'b00, psel, penable, paddr, pwrite, pstrb, pprot, pwdata};
      if (hready_o !== 1'b1) low++;
      if (pe < kk) begin
        chk("hready_busy", 64'(hready_o), 64'd0);
        chk("hresp_busy", 64'(hresp_o), 64'd0);
        exp_bus[56] = (pe >= 2);
        if (pe == 0) chk("apb_wait_idle", 64'({psel, penable}), 64'd0);
        else         chk("apb_bus", bus, exp_bus);
      end else if (v.exp_resp && !err1_seen) begin
        chk("err1_hready", 64'(hready_o), 64'd0);
        chk("err1_hresp", 64'(hresp_o), 64'd1);
        chk("err1_apb_idle", 64'({psel, penable}), 64'd0);
        err1_seen = 1;
      end else begin
        chk("done_hready", 64'(hready_o), 64'd1);
        chk("done_hresp", 64'(hresp_o), 64'(v.exp_resp));
        chk("done_apb_idle", 64'({psel, penable}), 64'd0);
        if (mapped && !v.wr && !v.exp_resp) exp_hrdata = v.rdata;
        chk("hrdata", 64'(hrdata_o), 64'(exp_hrdata));
        if (v.exp_low >= 0) chk("wait_states", 64'(low), 64'(v.exp_low));
        done = 1;
      end
      if (!done && cyc >= 300) begin
        n_checks++; n_err++;
        $display("FAIL xfer_budget: actual=no completion expected=completion addr=%0h", v.addr);
        done = 1;
      end
      if (!done) begin
        cyc++;
        pck = (v.pck_n == 0) ? 1'($urandom) : ((cyc % v.pck_n) == 0);
        pclken = pck;
        pready_i = 5'($urandom);
        if (mapped) pready_i[ii] = (pe >= 2 + v.wait_n);
        snap = bus;
        @(posedge hclk); #1;
        if (!pck) chk("apb_hold_no_pclken",
                      {2'b00, psel, penable, paddr, pwrite, pstrb, pprot, pwdata}, snap);
        if (pck && pe < kk) pe++;
      end
    end
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h4001_0004, 1'b1, 32'hDEAD_BEEF, 4'hF, 4'h3, 1, 0,   1'b0, 32'h0,         5'b00010, 1'b0, 3};
    tbl[1] = '{32'h4003_0010, 1'b0, 32'h0,         4'hF, 4'h2, 2, 2,   1'b0, 32'h1234_5678, 5'b01000, 1'b0, 10};
    tbl[2] = '{32'h4007_0000, 1'b1, 32'h5555_AAAA, 4'hF, 4'h1, 1, 0,   1'b0, 32'h0,         5'b00000, 1'b1, 1};
    tbl[3] = '{32'h5000_0000, 1'b0, 32'h0,         4'h0, 4'h1, 1, 0,   1'b0, 32'h0,         5'b00000, 1'b1, 1};
    tbl[4] = '{32'h4002_0008, 1'b0, 32'h0,         4'h0, 4'h0, 1, 1,   1'b1, 32'hCAFE_F00D, 5'b00100, 1'b1, 5};
    tbl[5] = '{32'h4004_0000, 1'b0, 32'h0,         4'h0, 4'h3, 1, 100, 1'b0, 32'h7777_0000, 5'b10000, 1'b1, 7};
    tbl[6] = '{32'h4000_00FC, 1'b1, 32'hA5A5_0001, 4'h5, 4'h1, 3, 0,   1'b0, 32'h0,         5'b00001, 1'b0, 9};
    tbl[7] = '{32'h4004_FFFC, 1'b0, 32'h0,         4'h0, 4'h2, 1, 3,   1'b0, 32'h0BAD_C0DE, 5'b10000, 1'b0, 6};
    tbl[8] = '{32'h4000_0000, 1'b0, 32'h0,         4'h0, 4'h0, 1, 0,   1'b0, 32'h1111_2222, 5'b00001, 1'b0, 3};

    hreset = 1'b1; pclken = 1'b0; hsel = 1'b0; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'b010; hprot = 4'h0; hwdata = 32'h0; hwstrb = 4'h0; hready_i = 1'b1;
    pready_i = 5'b0; pslverr_i = 5'b0; prdata_i = '0;
    repeat (3) @(posedge hclk);
    #1;
    chk("rst_hready", 64'(hready_o), 64'd1);
    chk("rst_hresp", 64'(hresp_o), 64'd0);
    chk("rst_psel_penable", 64'({psel, penable}), 64'd0);
    chk("rst_hrdata", 64'(hrdata_o), 64'd0);
    chk("rst_apb_fields", {8'h00, paddr, pwrite, pstrb, pprot, pwdata}, 64'd0);
    exp_hrdata = 32'h0;
    hreset = 1'b0;

    for (int i = 0; i < 9; i++) xfer(tbl[i]);

    // Reset in the middle of an ACCESS phase
    pready_i = 5'b0; pslverr_i = 5'b0; pclken = 1'b1;
    hsel = 1'b1; haddr = 32'h4004_0020; htrans = 2'b10; hwrite = 1'b0; hprot = 4'h0;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00;
    repeat (2) @(posedge hclk);
    #1;
    chk("mid_access_psel", 64'({psel, penable}), 64'({5'b10000, 1'b1}));
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    chk("mid_rst_psel_penable", 64'({psel, penable}), 64'd0);
    chk("mid_rst_hready", 64'(hready_o), 64'd1);
    chk("mid_rst_hresp", 64'(hresp_o), 64'd0);
    exp_hrdata = 32'h0;
    chk("mid_rst_hrdata", 64'(hrdata_o), 64'(exp_hrdata));
    rv = '{32'h4000_0040, 1'b0, 32'h0, 4'h0, 4'h2, 1, 1, 1'b0, 32'h0F0F_1234, 5'b00001, 1'b0, 4};
    xfer(rv);

    for (int i = 0; i < 60; i++) begin
      rv.addr   = {(($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'h400),
                   4'($urandom_range(0, 7)), 16'($urandom)};
      rv.wr     = 1'($urandom);
      rv.wdata  = $urandom;
      rv.strb   = 4'($urandom);
      rv.prot   = 4'($urandom);
      rv.pck_n  = $urandom_range(0, 3);
      rv.wait_n = $urandom_range(0, 5);
      rv.err    = ($urandom_range(0, 7) == 0);
      rv.rdata  = $urandom;
      xfer(mk_exp(rv));
      if ($urandom_range(0, 2) == 0) begin
        hsel = 1'b1; htrans = 2'b00; pclken = 1'($urandom);
        repeat ($urandom_range(1, 2)) @(posedge hclk);
        #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
